io_sequencer: RTL and testbench
===============================

# io_sequencer

Multicycle sequencer for the processor's IN/OUT instructions. When the control unit decodes an input read (ReadI) or output write (WriteO), this block stalls the PC. It then runs a handshake with the switch/button input device or the display output device, and releases the stall for exactly one retire cycle. It sits between the control unit, the register-file write mux and the external I/O pins.

## Interface
Parameters:
- DATA_W, 32, register/datapath width
- IN_W, 16, switch input width (IN_W ≤ DATA_W)
- SIGN_EXT, 1, 1 = sign-extend switch value to DATA_W, 0 = zero-extend
- SYNC_STAGES, 2, button synchronizer depth (≥ 2)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock, all state on rising edge
  - rst_n  in  1  asynchronous active-low reset
- Control-unit inputs:
  - read_i  in  1  ReadI from control unit (IN instruction in decode)
  - write_o  in  1  WriteO from control unit (OUT instruction in decode)
- Datapath and device inputs:
  - rd_data_i  in  DATA_W  register value to output
  - in_sw  in  IN_W  switch inputs, assumed stable while button pressed
  - in_btn  in  1  confirm button, asynchronous, active high
  - out_ready  in  1  display accepts out_data
- Outputs:
  - stall  out  1  hold PC and suppress register/memory writes
  - in_word  out  DATA_W  extended switch value to register-write mux
  - in_we  out  1  register-file write enable for in_word
  - out_data  out  DATA_W  value presented to display
  - out_valid  out  1  out_data valid, held until accepted
  - err  out  1  sticky: read_i and write_o asserted together

## Operation
States: IDLE, WAIT_IN, WAIT_OUT, DONE.

- IDLE:
  - read_i=1 → WAIT_IN. read_i has priority.
  - Else write_o=1 → latch rd_data_i into out_data and go to WAIT_OUT.
  - read_i & write_o → also set err. err clears only on reset.
- WAIT_IN: on a synchronized rising edge of in_btn, do three things at once:
  - capture in_sw, extended per SIGN_EXT, into in_word;
  - set in_we for the next cycle;
  - go to DONE.
- WAIT_OUT:
  - out_valid=1.
  - out_ready sampled 1 → go to DONE; out_valid is 0 from DONE onward.
  - out_data is retained after acceptance.
- DONE:
  - One cycle; always → IDLE.
  - read_i/write_o are ignored: the same instruction is still in decode.
  - in_we=1 only if DONE was entered from WAIT_IN.
- stall (combinational) = (IDLE & (read_i | write_o)) | WAIT_IN | WAIT_OUT. It is 0 in DONE, so the PC advances and the instruction retires.
- Button handling:
  - in_btn → SYNC_STAGES flops → edge = sync & ~sync_d.
  - An edge outside WAIT_IN is discarded, never queued.
  - A button held across entry into WAIT_IN does not count; a new rising edge is required.
- Extension: SIGN_EXT=1 replicates in_sw[IN_W-1]; 0 zero-fills. IN_W = DATA_W passes through unchanged.
- out_ready already high on entry to WAIT_OUT → accepted in the first WAIT_OUT cycle.

## Timing
- Reset values: state IDLE; in_word 0, in_we 0, out_data 0, out_valid 0, err 0, synchronizer flops 0.
  - stall follows its equation, so it is 0 unless read_i/write_o is high.
- Reset asserted mid-operation aborts immediately and asynchronously:
  - out_valid drops;
  - no in_we pulse;
  - the pending instruction must be re-executed after reset.
- OUT latency: write_o seen at edge 0 → first WAIT_OUT cycle after edge 0 → DONE one cycle after out_ready is sampled → IDLE.
  - Minimum stall is 2 cycles: the IDLE request cycle plus one WAIT_OUT.
- IN latency:
  - in_btn rising before edge k → edge detected in the cycle after edge k+SYNC_STAGES-1.
  - Capture happens at the following edge; in_we is high in the DONE cycle.
  - The register write commits at the edge ending DONE, coincident with the PC update.
- in_we is a one-cycle pulse. in_word is held until the next capture.

## Structure
- Package io_seq_pkg:
  - state enum io_state_t {IDLE, WAIT_IN, WAIT_OUT, DONE}, 2-bit encoding;
  - default width constants.
- Sub-module btn_sync_edge:
  - parameter SYNC_STAGES;
  - ports clk, rst_n, async_in, edge_out;
  - synchronizer plus rising-edge detector.
- The FSM, capture registers and stall logic live in io_sequencer.

## Test plan
- Reset:
  - Reset while in WAIT_OUT with out_valid=1 → out_valid=0 immediately, state IDLE, err=0.
  - Reset while in WAIT_IN → no in_we pulse after reset releases.
- OUT handshake:
  - write_o=1, rd_data_i=0x0000_00A5, out_ready held low 5 cycles → stall=1 and out_data=0xA5 throughout, out_valid=1.
  - Raise out_ready → one DONE cycle with stall=0, then IDLE.
- IN, SIGN_EXT=1: read_i=1, in_sw=0x8001, pulse in_btn → in_word=0xFFFF_8001, in_we one cycle, stall drops in the same cycle.
  - Repeat with SIGN_EXT=0 → in_word=0x0000_8001.
- Stray and held button:
  - Button edge in IDLE, then read_i → remains in WAIT_IN, no capture.
  - Button held high on entry into WAIT_IN → no capture until release and a new press.
- Conflict: read_i=write_o=1 → err=1 sticky, WAIT_IN taken, out_valid stays 0.
- Back-to-back:
  - Hold read_i high through DONE → no re-trigger in DONE.
  - A new request in the following IDLE cycle starts a second transaction.

Source files
------------

// File: rtl/io_seq_pkg.sv
// io_seq_pkg: shared types and default sizes for the IN/OUT instruction sequencer.
//   io_state_t     - sequencer state, 2-bit encoding
//   DEF_*          - default parameter values used by io_sequencer
package io_seq_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_IN_W        = 16;
    localparam bit DEF_SIGN_EXT    = 1'b1;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IN  = 2'd1,
        WAIT_OUT = 2'd2,
        DONE     = 2'd3
    } io_state_t;

endpackage

// File: rtl/io_sequencer_btn_sync.sv
// btn_sync_edge: brings the asynchronous confirm button into the clk domain
// and produces a one-cycle pulse on each synchronized rising edge.
//   clk, rst_n  - clock, asynchronous active-low reset
//   async_in    - raw button level
//   edge_out    - high for one cycle after a synchronized 0->1 transition
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/io_sequencer.sv
// io_sequencer: multicycle sequencer for IN/OUT instructions. Stalls the PC
// while waiting on the switch/button input device or the display, then lets
// the instruction retire in a single DONE cycle.
//   read_i, write_o  - IN / OUT instruction decoded (read_i wins if both)
//   rd_data_i        - register value to display
//   in_sw, in_btn    - switch value and asynchronous confirm button
//   out_ready        - display accepts out_data
//   stall            - hold PC, suppress writes
//   in_word, in_we   - extended switch value and its register write enable
//   out_data, out_valid - display value and its valid flag
//   err              - sticky: read_i and write_o requested together
module io_sequencer
    import io_seq_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IN_W        = DEF_IN_W,
    parameter bit SIGN_EXT    = DEF_SIGN_EXT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_i,
    input  logic              write_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [IN_W-1:0]   in_sw,
    input  logic              in_btn,
    input  logic              out_ready,
    output logic              stall,
    output logic [DATA_W-1:0] in_word,
    output logic              in_we,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              err
);

    io_state_t         state, state_next;
    logic              btn_edge;
    logic              capture;
    logic [DATA_W-1:0] sw_ext;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (in_btn),
        .edge_out (btn_edge)
    );

    // Edges seen outside WAIT_IN are simply dropped, never queued.
    assign capture = (state == WAIT_IN) && btn_edge;

    // Fill the upper bits first, then overlay the switch value; this also
    // covers IN_W == DATA_W without a zero-width replication.
    always_comb begin
        sw_ext             = SIGN_EXT ? {DATA_W{in_sw[IN_W-1]}} : '0;
        sw_ext[IN_W-1:0]   = in_sw;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (read_i)       state_next = WAIT_IN;
                else if (write_o) state_next = WAIT_OUT;
            end
            WAIT_IN:  if (btn_edge)  state_next = DONE;
            WAIT_OUT: if (out_ready) state_next = DONE;
            DONE:     state_next = IDLE;   // same instruction still in decode
            default:  state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall     = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:     stall = read_i | write_o;
            WAIT_IN:  stall = 1'b1;
            WAIT_OUT: begin
                stall     = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture registers and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_word  <= '0;
            in_we    <= 1'b0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            in_we <= capture;
            if (capture) in_word <= sw_ext;
            if (state == IDLE && write_o && !read_i) out_data <= rd_data_i;
            if (state == IDLE && read_i && write_o)  err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_sequencer.sv
module tb_io_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_i, write_o, in_btn, out_ready;
    logic [31:0] rd_data_i;
    logic [15:0] in_sw;

    logic        stall_s, in_we_s, out_valid_s, err_s;
    logic [31:0] in_word_s, out_data_s;
    logic        stall_z, in_we_z, out_valid_z, err_z;
    logic [31:0] in_word_z, out_data_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_sequencer #(.DATA_W(32), .IN_W(16), .SIGN_EXT(1'b1), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_o(write_o),
        .rd_data_i(rd_data_i), .in_sw(in_sw), .in_btn(in_btn), .out_ready(out_ready),
        .stall(stall_s), .in_word(in_word_s), .in_we(in_we_s),
        .out_data(out_data_s), .out_valid(out_valid_s), .err(err_s)
    );

    io_sequencer #(.DATA_W(32), .IN_W(16), .SIGN_EXT(1'b0), .SYNC_STAGES(2)) dut_z (
        .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_o(write_o),
        .rd_data_i(rd_data_i), .in_sw(in_sw), .in_btn(in_btn), .out_ready(out_ready),
        .stall(stall_z), .in_word(in_word_z), .in_we(in_we_z),
        .out_data(out_data_z), .out_valid(out_valid_z), .err(err_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; read_i = 0; write_o = 0; in_btn = 0; out_ready = 0;
        rd_data_i = '0; in_sw = '0;
        #12;
        check("rst_stall",     stall_s, 0);
        check("rst_out_valid", out_valid_s, 0);
        check("rst_err",       err_s, 0);
        check("rst_in_we",     in_we_s, 0);
        check("rst_in_word",   in_word_s, 0);
        check("rst_out_data",  out_data_s, 0);
        tick(); rst_n = 1'b1;

        // OUT handshake with display slow to accept
        tick(); write_o = 1; rd_data_i = 32'h0000_00A5; settle();
        check("out_req_stall", stall_s, 1);
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            check("out_wait_stall", stall_s, 1);
            check("out_wait_valid", out_valid_s, 1);
            check("out_wait_data",  out_data_s, 32'hA5);
        end
        out_ready = 1;
        tick(); settle();
        check("out_done_stall", stall_s, 0);
        check("out_done_valid", out_valid_s, 0);
        check("out_done_data",  out_data_s, 32'hA5);
        check("out_done_we",    in_we_s, 0);
        write_o = 0; out_ready = 0;
        tick(); settle();
        check("out_idle_stall", stall_s, 0);

        // Reset during WAIT_OUT
        write_o = 1; rd_data_i = 32'h0000_1234;
        tick(); settle();
        check("wo_valid_pre", out_valid_s, 1);
        rst_n = 1'b0; settle();
        check("rst_wo_valid", out_valid_s, 0);
        check("rst_wo_stall", stall_s, 1);   // IDLE with write_o still high
        check("rst_wo_err",   err_s, 0);
        check("rst_wo_data",  out_data_s, 0);
        write_o = 0;
        tick(); rst_n = 1'b1;

        // IN with button pulse: sign and zero extension
        tick(); read_i = 1; in_sw = 16'h8001;
        tick(); in_btn = 1; settle();
        check("in_wait_stall", stall_s, 1);
        tick(); settle();
        check("in_sync1_we", in_we_s, 0);
        tick(); settle();
        check("in_sync2_stall", stall_s, 1);
        check("in_sync2_we",    in_we_s, 0);
        tick(); settle();
        check("in_done_we",     in_we_s, 1);
        check("in_done_stall",  stall_s, 0);
        check("in_word_sext",   in_word_s, 32'hFFFF_8001);
        check("in_word_zext",   in_word_z, 32'h0000_8001);
        check("in_done_we_z",   in_we_z, 1);
        read_i = 0; in_btn = 0;
        tick(); settle();
        check("in_we_pulse",    in_we_s, 0);
        check("in_word_hold",   in_word_s, 32'hFFFF_8001);

        // Reset during WAIT_IN, just before capture would happen
        read_i = 1; in_sw = 16'h0F0F;
        tick(); in_btn = 1;
        tick(); tick();
        rst_n = 1'b0; settle();
        check("rst_wi_we",   in_we_s, 0);
        check("rst_wi_word", in_word_s, 0);
        read_i = 0; in_btn = 0;
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("rst_wi_no_we", in_we_s, 0);
        end

        // Stray button edge in IDLE is discarded
        in_btn = 1; tick(); tick(); tick();
        in_btn = 0; tick(); tick();
        read_i = 1; in_sw = 16'h1234;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check("stray_stall", stall_s, 1);
            check("stray_we",    in_we_s, 0);
        end
        in_btn = 1; tick(); tick(); tick(); settle();
        check("stray_cap_we",   in_we_s, 1);
        check("stray_cap_word", in_word_s, 32'h0000_1234);
        read_i = 0; in_btn = 0; tick();

        // Button held high across entry into WAIT_IN
        in_btn = 1; tick(); tick(); tick();
        read_i = 1; in_sw = 16'h7FFF;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("held_stall", stall_s, 1);
            check("held_we",    in_we_s, 0);
        end
        in_btn = 0; tick(); tick(); tick();
        in_btn = 1; tick(); tick(); tick(); settle();
        check("held_cap_we",   in_we_s, 1);
        check("held_cap_sext", in_word_s, 32'h0000_7FFF);
        check("held_cap_zext", in_word_z, 32'h0000_7FFF);
        read_i = 0; in_btn = 0; tick();

        // Conflict: read_i wins, err sticks
        read_i = 1; write_o = 1; in_sw = 16'hFFFF; rd_data_i = 32'hDEAD_BEEF; settle();
        check("conf_req_stall", stall_s, 1);
        check("conf_req_err",   err_s, 0);
        tick(); write_o = 0; settle();
        check("conf_err",       err_s, 1);
        check("conf_valid",     out_valid_s, 0);
        check("conf_out_data",  out_data_s, 0);
        check("conf_stall",     stall_s, 1);
        in_btn = 1; tick(); tick(); tick(); settle();
        check("conf_we",        in_we_s, 1);
        check("conf_word_s",    in_word_s, 32'hFFFF_FFFF);
        check("conf_word_z",    in_word_z, 32'h0000_FFFF);
        check("conf_done_stall", stall_s, 0);

        // Back-to-back: read_i held through DONE, second transaction follows
        tick(); settle();
        check("b2b_idle_stall", stall_s, 1);
        check("b2b_idle_we",    in_we_s, 0);
        tick(); settle();
        check("b2b_wait_stall", stall_s, 1);
        check("b2b_wait_we",    in_we_s, 0);
        in_btn = 0; tick(); tick(); tick();
        in_sw = 16'h0042; in_btn = 1;
        tick(); tick(); tick(); settle();
        check("b2b_we",     in_we_s, 1);
        check("b2b_word",   in_word_s, 32'h0000_0042);
        check("b2b_err",    err_s, 1);
        read_i = 0; in_btn = 0; tick();

        // out_ready already high: accepted in the first WAIT_OUT cycle
        out_ready = 1; write_o = 1; rd_data_i = 32'h0000_0055;
        tick(); settle();
        check("fast_valid", out_valid_s, 1);
        check("fast_stall", stall_s, 1);
        tick(); settle();
        check("fast_done_stall", stall_s, 0);
        check("fast_done_valid", out_valid_s, 0);
        check("fast_data",       out_data_s, 32'h0000_0055);
        write_o = 0; out_ready = 0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
